sdram_arbit: RTL and testbench

//  Central arbiter/sequencer for the single SDRAM command bus. Waits for power-up init, then grants the
//  bus to auto-refresh, write or read engines, muxes each engine's cmd/addr onto the pins, and owns DQ

---
 rtl/sdram_arbit_pkg.sv | 26 ++
 rtl/sdram_arbit_if.sv | 55 +++++
 rtl/sdram_arbit.sv | 123 ++++++++++++
 tb/tb_sdram_arbit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbit_pkg.sv
// Shared definitions for the SDRAM command-bus arbiter: state encodings and SDRAM
// command words in {CS_N,RAS_N,CAS_N,WE_N} order.
package sdram_arbit_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 16;

  typedef logic [3:0] sdram_cmd_t;

  localparam sdram_cmd_t CMD_NOP       = 4'b0111;
  localparam sdram_cmd_t CMD_PRECHARGE = 4'b0010;
  localparam sdram_cmd_t CMD_AREF      = 4'b0001;
  localparam sdram_cmd_t CMD_ACTIVE    = 4'b0011;
  localparam sdram_cmd_t CMD_WRITE     = 4'b0100;
  localparam sdram_cmd_t CMD_READ      = 4'b0101;
  localparam sdram_cmd_t CMD_MODE      = 4'b0000;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ARBIT = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } state_e;

endpackage

// File: rtl/sdram_arbit_if.sv
// Engine-side request/grant/command signals plus the SDRAM pin-side outputs of the arbiter.
// slave = the arbiter, master = the engines and pad logic around it.
interface sdram_arbit_if #(
  parameter int ADDR_W = sdram_arbit_pkg::ADDR_W_DEF,
  parameter int DATA_W = sdram_arbit_pkg::DATA_W_DEF
);

  logic              flag_init_end;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;

  logic              aref_req;
  logic              flag_aref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_en;

  logic              wr_req;
  logic              flag_wr_end;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  logic              rd_req;
  logic              flag_rd_end;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;

  logic [3:0]        sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic              dq_oe;
  logic [DATA_W-1:0] dq_out;
  logic [4:0]        state;

  modport slave (
    input  flag_init_end, init_cmd, init_addr,
    input  aref_req, flag_aref_end, aref_cmd, aref_addr,
    input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_data,
    input  rd_req, flag_rd_end, rd_cmd, rd_addr,
    output aref_en, wr_en, rd_en,
    output sdram_cmd, sdram_addr, dq_oe, dq_out, state
  );

  modport master (
    output flag_init_end, init_cmd, init_addr,
    output aref_req, flag_aref_end, aref_cmd, aref_addr,
    output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_data,
    output rd_req, flag_rd_end, rd_cmd, rd_addr,
    input  aref_en, wr_en, rd_en,
    input  sdram_cmd, sdram_addr, dq_oe, dq_out, state
  );

endinterface

// File: rtl/sdram_arbit.sv
// Owner of the single SDRAM command bus: waits for init, then grants refresh, write or
// read engines (refresh first, write/read round-robin) and muxes the winner onto the pins.
import sdram_arbit_pkg::*;

module sdram_arbit #(
  parameter int         ADDR_W  = ADDR_W_DEF,
  parameter int         DATA_W  = DATA_W_DEF,
  parameter logic [3:0] CMD_NOP = sdram_arbit_pkg::CMD_NOP
) (
  input  logic          clk,
  input  logic          rst_n,
  sdram_arbit_if.slave  bus
);

  state_e            r_state;
  logic              r_aref_en;
  logic              r_wr_en;
  logic              r_rd_en;
  logic              r_last_wr;

  logic [3:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic              w_dq_oe;
  logic [DATA_W-1:0] w_dq_out;
  logic              w_wr_wins;

  // On a wr/rd tie the side not served last wins; a lone requester always wins.
  assign w_wr_wins = bus.wr_req && (!bus.rd_req || !r_last_wr);

  // NOTE: all state and grant flops use non-blocking assignments so every branch
  // sees the pre-edge values and the grant asserts on the same edge as the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_aref_en <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_last_wr <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.flag_init_end) r_state <= ST_ARBIT;
        end
        ST_ARBIT: begin
          if (bus.aref_req) begin
            r_state   <= ST_AREF;
            r_aref_en <= 1'b1;
          end else if (w_wr_wins) begin
            r_state   <= ST_WRITE;
            r_wr_en   <= 1'b1;
            r_last_wr <= 1'b1;
          end else if (bus.rd_req) begin
            r_state   <= ST_READ;
            r_rd_en   <= 1'b1;
            r_last_wr <= 1'b0;
          end
        end
        ST_AREF: begin
          if (bus.flag_aref_end) begin
            r_state   <= ST_ARBIT;
            r_aref_en <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (bus.flag_wr_end) r_state <= ST_ARBIT;
        end
        ST_READ: begin
          if (bus.flag_rd_end) r_state <= ST_ARBIT;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_aref_en <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred;
  // the defaults double as the safe values for a corrupted state register.
  always_comb begin
    w_cmd   = CMD_NOP;
    w_addr  = '0;
    w_dq_oe = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmd  = bus.init_cmd;
        w_addr = bus.init_addr;
      end
      ST_ARBIT: begin
        w_cmd  = CMD_NOP;
        w_addr = bus.init_addr;
      end
      ST_AREF: begin
        w_cmd  = bus.aref_cmd;
        w_addr = bus.aref_addr;
      end
      ST_WRITE: begin
        w_cmd   = bus.wr_cmd;
        w_addr  = bus.wr_addr;
        w_dq_oe = 1'b1;
      end
      ST_READ: begin
        w_cmd  = bus.rd_cmd;
        w_addr = bus.rd_addr;
      end
      default: ;
    endcase
  end

  assign w_dq_out = bus.wr_data;

  assign bus.sdram_cmd  = w_cmd;
  assign bus.sdram_addr = w_addr;
  assign bus.dq_oe      = w_dq_oe;
  assign bus.dq_out     = w_dq_out;
  assign bus.state      = r_state;
  assign bus.aref_en    = r_aref_en;
  assign bus.wr_en      = r_wr_en;
  assign bus.rd_en      = r_rd_en;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: table of ARBIT request patterns plus hand sequences for the
// multi-cycle corners; a grant-order queue is checked by a monitor on each grant pulse.
module tb_sdram_arbit;
  import sdram_arbit_pkg::*;

  localparam int AW = 13;
  localparam int DW = 16;

  localparam logic [3:0]    INIT_CMD  = 4'b0010;
  localparam logic [AW-1:0] INIT_ADDR = 13'h0400;
  localparam logic [3:0]    AREF_CMD  = 4'b0001;
  localparam logic [AW-1:0] AREF_ADDR = 13'h0011;
  localparam logic [3:0]    WR_CMD    = 4'b0100;
  localparam logic [AW-1:0] WR_ADDR   = 13'h0222;
  localparam logic [3:0]    RD_CMD    = 4'b0101;
  localparam logic [AW-1:0] RD_ADDR   = 13'h0333;
  localparam logic [DW-1:0] WR_DATA   = 16'hA5C3;

  localparam logic [1:0] G_AREF = 2'd1;
  localparam logic [1:0] G_WR   = 2'd2;
  localparam logic [1:0] G_RD   = 2'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  sdram_arbit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_arbit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: each rising grant is compared against the next queued expectation.
  logic       prev_a = 1'b0, prev_w = 1'b0, prev_r = 1'b0;
  logic [1:0] mon_g;
  always @(negedge clk) begin
    mon_g = 2'd0;
    if (bus.aref_en && !prev_a) mon_g = G_AREF;
    if (bus.wr_en && !prev_w)   mon_g = G_WR;
    if (bus.rd_en && !prev_r)   mon_g = G_RD;
    if (mon_g != 2'd0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL grant_unexpected actual=%0d expected=none", mon_g);
      end else begin
        check("grant_order", {30'd0, mon_g}, {30'd0, exp_q.pop_front()});
      end
    end
    prev_a = bus.aref_en;
    prev_w = bus.wr_en;
    prev_r = bus.rd_en;
  end

  function automatic logic [3:0] m_cmd(input state_e st);
    case (st)
      ST_IDLE:  return INIT_CMD;
      ST_AREF:  return AREF_CMD;
      ST_WRITE: return WR_CMD;
      ST_READ:  return RD_CMD;
      default:  return 4'b0111;
    endcase
  endfunction

  function automatic logic [AW-1:0] m_addr(input state_e st);
    case (st)
      ST_AREF:  return AREF_ADDR;
      ST_WRITE: return WR_ADDR;
      ST_READ:  return RD_ADDR;
      default:  return INIT_ADDR;
    endcase
  endfunction

  function automatic logic [1:0] m_grant(input state_e st);
    case (st)
      ST_AREF:  return G_AREF;
      ST_WRITE: return G_WR;
      default:  return G_RD;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_outs(input string tag, input state_e st, input logic ae,
                            input logic we, input logic re);
    check({tag, "_state"},   {27'd0, bus.state},      {27'd0, st});
    check({tag, "_aref_en"}, {31'd0, bus.aref_en},    {31'd0, ae});
    check({tag, "_wr_en"},   {31'd0, bus.wr_en},      {31'd0, we});
    check({tag, "_rd_en"},   {31'd0, bus.rd_en},      {31'd0, re});
    check({tag, "_cmd"},     {28'd0, bus.sdram_cmd},  {28'd0, m_cmd(st)});
    check({tag, "_addr"},    {19'd0, bus.sdram_addr}, {19'd0, m_addr(st)});
    check({tag, "_dq_oe"},   {31'd0, bus.dq_oe},      {31'd0, (st == ST_WRITE)});
    if (st == ST_WRITE) check({tag, "_dq_out"}, {16'd0, bus.dq_out}, {16'd0, WR_DATA});
  endtask

  task automatic end_burst(input state_e st);
    case (st)
      ST_AREF:  bus.flag_aref_end = 1'b1;
      ST_WRITE: bus.flag_wr_end   = 1'b1;
      default:  bus.flag_rd_end   = 1'b1;
    endcase
    step();
    bus.flag_aref_end = 1'b0;
    bus.flag_wr_end   = 1'b0;
    bus.flag_rd_end   = 1'b0;
  endtask

  typedef struct {
    logic   aref;
    logic   wr;
    logic   rd;
    state_e exp_st;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Round-robin history is tracked by hand: last_wr starts 0 after reset.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, ST_AREF};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, ST_AREF};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, ST_WRITE};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, ST_READ};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, ST_WRITE};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, ST_READ};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, ST_READ};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, ST_WRITE};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, ST_WRITE};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, ST_READ};
    vecs[10] = '{1'b1, 1'b1, 1'b0, ST_AREF};
    vecs[11] = '{1'b0, 1'b0, 1'b0, ST_ARBIT};

    bus.flag_init_end = 1'b0;
    bus.init_cmd      = INIT_CMD;
    bus.init_addr     = INIT_ADDR;
    bus.aref_req      = 1'b0;
    bus.flag_aref_end = 1'b0;
    bus.aref_cmd      = AREF_CMD;
    bus.aref_addr     = AREF_ADDR;
    bus.wr_req        = 1'b0;
    bus.flag_wr_end   = 1'b0;
    bus.wr_cmd        = WR_CMD;
    bus.wr_addr       = WR_ADDR;
    bus.wr_data       = WR_DATA;
    bus.rd_req        = 1'b0;
    bus.flag_rd_end   = 1'b0;
    bus.rd_cmd        = RD_CMD;
    bus.rd_addr       = RD_ADDR;

    step();
    step();
    check_outs("reset", ST_IDLE, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Requests and end flags before init completes must be ignored.
    bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.flag_wr_end = 1'b1;
    repeat (3) step();
    check_outs("idle_ignore", ST_IDLE, 1'b0, 1'b0, 1'b0);
    bus.aref_req = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.flag_wr_end = 1'b0;

    while (cyc < 10) step();
    check_outs("pre_init", ST_IDLE, 1'b0, 1'b0, 1'b0);
    bus.flag_init_end = 1'b1;
    step();
    bus.flag_init_end = 1'b0;
    check_outs("init_done", ST_ARBIT, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("arbit_idle", ST_ARBIT, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      bus.aref_req = vecs[i].aref;
      bus.wr_req   = vecs[i].wr;
      bus.rd_req   = vecs[i].rd;
      if (vecs[i].exp_st != ST_ARBIT) exp_q.push_back(m_grant(vecs[i].exp_st));
      step();
      bus.aref_req = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
      check_outs($sformatf("vec%0d_grant", i), vecs[i].exp_st, (vecs[i].exp_st == ST_AREF),
                 (vecs[i].exp_st == ST_WRITE), (vecs[i].exp_st == ST_READ));
      if (vecs[i].exp_st != ST_ARBIT) begin
        step();
        check_outs($sformatf("vec%0d_hold", i), vecs[i].exp_st, (vecs[i].exp_st == ST_AREF),
                   1'b0, 1'b0);
        end_burst(vecs[i].exp_st);
        check_outs($sformatf("vec%0d_end", i), ST_ARBIT, 1'b0, 1'b0, 1'b0);
      end
    end

    // Foreign end flags during READ are ignored.
    bus.rd_req = 1'b1;
    exp_q.push_back(G_RD);
    step();
    bus.rd_req = 1'b0;
    bus.flag_wr_end = 1'b1; bus.flag_aref_end = 1'b1;
    step();
    bus.flag_wr_end = 1'b0; bus.flag_aref_end = 1'b0;
    check_outs("stray_read", ST_READ, 1'b0, 1'b0, 1'b0);
    end_burst(ST_READ);
    check_outs("stray_read_end", ST_ARBIT, 1'b0, 1'b0, 1'b0);

    // End flag coinciding with the grant edge does not end the burst.
    bus.wr_req = 1'b1; bus.flag_wr_end = 1'b1;
    exp_q.push_back(G_WR);
    step();
    bus.wr_req = 1'b0; bus.flag_wr_end = 1'b0;
    check_outs("flag_at_grant", ST_WRITE, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("flag_at_grant_hold", ST_WRITE, 1'b0, 1'b0, 1'b0);
    end_burst(ST_WRITE);
    check_outs("flag_at_grant_end", ST_ARBIT, 1'b0, 1'b0, 1'b0);

    // Reset mid-write: immediate return to reset values; init needed again.
    bus.wr_req = 1'b1;
    exp_q.push_back(G_WR);
    step();
    check_outs("rst_pre", ST_WRITE, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_outs("rst_write", ST_IDLE, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    bus.rd_req = 1'b1;
    repeat (3) step();
    check_outs("rst_wait_init", ST_IDLE, 1'b0, 1'b0, 1'b0);
    bus.flag_init_end = 1'b1;
    step();
    bus.flag_init_end = 1'b0;
    check_outs("rst_reinit", ST_ARBIT, 1'b0, 1'b0, 1'b0);
    // last_wr was 1 before reset; a cleared flop lets write win the tie.
    exp_q.push_back(G_WR);
    step();
    bus.rd_req = 1'b0;
    check_outs("rst_tie_write", ST_WRITE, 1'b0, 1'b1, 1'b0);
    bus.wr_req = 1'b1;
    end_burst(ST_WRITE);
    check_outs("rst_tie_end", ST_ARBIT, 1'b0, 1'b0, 1'b0);

    // Both requests held through four bursts: strict alternation, READ first now.
    bus.rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      automatic state_e st = (k % 2 == 0) ? ST_READ : ST_WRITE;
      exp_q.push_back(m_grant(st));
      step();
      check_outs($sformatf("rr%0d_grant", k), st, 1'b0, (st == ST_WRITE), (st == ST_READ));
      end_burst(st);
      check_outs($sformatf("rr%0d_nop", k), ST_ARBIT, 1'b0, 1'b0, 1'b0);
    end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;

    step();
    step();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
